// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem bus-master initiator.
// Holds FSM state encoding, read strobe value and peripheral page ids.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] IOMEM_WSTRB_READ = 4'b0000;

  localparam logic [7:0] PAGE_GPIO    = 8'h03;
  localparam logic [7:0] PAGE_MMIO    = 8'h06;
  localparam logic [7:0] PAGE_FP_GPIO = 8'h07;

  // Reads go out with an all-zero strobe; writes keep their enables.
  function automatic logic [3:0] bus_wstrb(
    input logic       write,
    input logic [3:0] wstrb
  );
    return write ? wstrb : IOMEM_WSTRB_READ;
  endfunction

endpackage

// File: rtl/iomem_wait_ctr.sv
// Wait counter with synchronous clear, count enable and terminal flag.
// Ports: clk, rst_n (async low), clr, en in; tc out (count == TC).
module iomem_wait_ctr #(
  parameter int W  = 9,
  parameter int TC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == W'(TC));

endmodule

// File: rtl/iomem_initiator.sv
// Bus-master end of the PicoSoC iomem interface, one transaction at a time.
// Ports: cmd_* request channel in, rsp_* response channel out, iomem_* bus.
// Optional IOMEM_INIT_TIMEOUT_EN: abandon a bus cycle after TIMEOUT_CYCLES.
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        iomem_valid_q, iomem_valid_d;
  logic [3:0]  iomem_wstrb_q, iomem_wstrb_d;
  logic [31:0] iomem_addr_q, iomem_addr_d;
  logic [31:0] iomem_wdata_q, iomem_wdata_d;
  logic        write_q, write_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        accept;
  logic        timeout;

  assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;

`ifdef IOMEM_INIT_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;
  logic ctr_en;
  logic ctr_tc;

  assign ctr_en  = (state_q == ST_BUS) && !iomem_ready;
  // Ready in the terminal cycle takes priority over the timeout.
  assign timeout = ctr_en && ctr_tc;

  iomem_wait_ctr #(
    .W  (CNT_W),
    .TC (TIMEOUT_CYCLES - 1)
  ) u_wait_ctr (
    .clk   (clk),
    .rst_n (resetn),
    .clr   (accept),
    .en    (ctr_en),
    .tc    (ctr_tc)
  );
`else
  logic [CNT_W-1:0] unused_tmo;
  assign unused_tmo = CNT_W'(TIMEOUT_CYCLES);
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    iomem_valid_d = iomem_valid_q;
    iomem_wstrb_d = iomem_wstrb_q;
    iomem_addr_d  = iomem_addr_q;
    iomem_wdata_d = iomem_wdata_q;
    write_d       = write_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
`ifdef IOMEM_INIT_TIMEOUT_EN
    rsp_err_d     = rsp_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          iomem_addr_d  = cmd_addr;
          iomem_wdata_d = cmd_wdata;
          iomem_wstrb_d = bus_wstrb(cmd_write, cmd_wstrb);
          write_d       = cmd_write;
          iomem_valid_d = 1'b1;
          state_d       = ST_BUS;
        end
      end
      ST_BUS: begin
        // Valid drops on the ready edge so responders never retrigger.
        if (iomem_ready) begin
          iomem_valid_d = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = write_q ? 32'h0 : iomem_rdata;
`ifdef IOMEM_INIT_TIMEOUT_EN
          rsp_err_d     = 1'b0;
`endif
          state_d       = ST_RESP;
        end else if (timeout) begin
          iomem_valid_d = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = 32'h0;
`ifdef IOMEM_INIT_TIMEOUT_EN
          rsp_err_d     = 1'b1;
`endif
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        iomem_valid_d = 1'b0;
        rsp_valid_d   = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      iomem_valid_q <= 1'b0;
      iomem_wstrb_q <= '0;
      iomem_addr_q  <= '0;
      iomem_wdata_q <= '0;
      write_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      iomem_valid_q <= iomem_valid_d;
      iomem_wstrb_q <= iomem_wstrb_d;
      iomem_addr_q  <= iomem_addr_d;
      iomem_wdata_q <= iomem_wdata_d;
      write_q       <= write_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

`ifdef IOMEM_INIT_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign cmd_ready   = cmd_ready_q;
  assign iomem_valid = iomem_valid_q;
  assign iomem_wstrb = iomem_wstrb_q;
  assign iomem_addr  = iomem_addr_q;
  assign iomem_wdata = iomem_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed bench for iomem_initiator with a stub responder of set delay.
// Timeout scenarios are built only when IOMEM_INIT_TIMEOUT_EN is defined.
module tb_iomem_initiator;
  import iomem_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata = '0;

  int compared = 0;
  int mismatched = 0;

  bit          stub_en = 1'b1;
  int          stub_delay = 1;
  int          stub_cnt = 0;
  logic [31:0] stub_data = '0;

  int          vcyc = 0;
  logic [3:0]  seen_wstrb;
  logic [31:0] seen_addr;
  logic [31:0] seen_wdata;

  iomem_initiator #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata)
  );

  always #5 clk = ~clk;

  // Stub responder: ready pulses in the stub_delay-th cycle of valid.
  always @(posedge clk) begin
    #1;
    iomem_ready = 1'b0;
    if (stub_en && iomem_valid) begin
      stub_cnt++;
      if (stub_cnt == stub_delay) begin
        iomem_ready = 1'b1;
        iomem_rdata = stub_data;
        stub_cnt    = 0;
      end
    end else begin
      stub_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (iomem_valid) begin
      vcyc++;
      seen_wstrb = iomem_wstrb;
      seen_addr  = iomem_addr;
      seen_wdata = iomem_wdata;
    end
  end

  task automatic send_cmd(
    input logic        w,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      compared++; mismatched++;
      $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    vcyc      = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) begin
      compared++; mismatched++;
      $display("FAIL rsp_wait: rsp_valid got %b want 1", rsp_valid);
    end
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    compared++;
    if (rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rsp_drop: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    compared++;
    if ({cmd_ready, rsp_valid, rsp_err, iomem_valid} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_ctl: got %b want 0000",
               {cmd_ready, rsp_valid, rsp_err, iomem_valid});
    end
    compared++;
    if ({iomem_wstrb, iomem_addr, iomem_wdata, rsp_rdata} !== '0) begin
      mismatched++;
      $display("FAIL reset_data: got %h %h %h %h want 0",
               iomem_wstrb, iomem_addr, iomem_wdata, rsp_rdata);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_idle_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    stub_en = 1'b1; stub_delay = 1; stub_data = 32'hDEAD_BEEF;
    send_cmd(1'b1, {PAGE_GPIO, 24'h0}, 32'h0000_00A5, 4'b0001);
    wait_rsp();
    compared++;
    if (vcyc !== 1) begin
      mismatched++;
      $display("FAIL wr_valid_cycles: got %0d want 1", vcyc);
    end
    compared++;
    if ({seen_wstrb, seen_addr, seen_wdata} !== {4'b0001, 32'h0300_0000, 32'h0000_00A5}) begin
      mismatched++;
      $display("FAIL wr_bus: got %b %h %h want 0001 03000000 000000a5",
               seen_wstrb, seen_addr, seen_wdata);
    end
    compared++;
    if ({rsp_err, rsp_rdata} !== {1'b0, 32'h0}) begin
      mismatched++;
      $display("FAIL wr_rsp: got err=%b rdata=%h want 0 0", rsp_err, rsp_rdata);
    end
    consume_rsp();
  endtask

  task automatic test_read();
    stub_en = 1'b1; stub_delay = 3; stub_data = 32'h0000_0003;
    send_cmd(1'b0, {PAGE_FP_GPIO, 24'h4}, 32'hFFFF_FFFF, 4'b1111);
    wait_rsp();
    compared++;
    if (vcyc !== 3) begin
      mismatched++;
      $display("FAIL rd_valid_cycles: got %0d want 3", vcyc);
    end
    compared++;
    if ({seen_wstrb, seen_addr} !== {4'b0000, 32'h0700_0004}) begin
      mismatched++;
      $display("FAIL rd_bus: got %b %h want 0000 07000004", seen_wstrb, seen_addr);
    end
    compared++;
    if ({rsp_err, rsp_rdata} !== {1'b0, 32'h3}) begin
      mismatched++;
      $display("FAIL rd_rsp: got err=%b rdata=%h want 0 3", rsp_err, rsp_rdata);
    end
    consume_rsp();
  endtask

  task automatic test_wstrb_zero();
    stub_en = 1'b1; stub_delay = 1; stub_data = 32'h1111_2222;
    send_cmd(1'b1, {PAGE_MMIO, 24'h10}, 32'h0BAD_F00D, 4'b0000);
    wait_rsp();
    compared++;
    if ({seen_wstrb, seen_wdata} !== {4'b0000, 32'h0BAD_F00D}) begin
      mismatched++;
      $display("FAIL wz_bus: got %b %h want 0000 0badf00d", seen_wstrb, seen_wdata);
    end
    compared++;
    if (rsp_rdata !== 32'h0) begin
      mismatched++;
      $display("FAIL wz_rdata: got %h want 0", rsp_rdata);
    end
    consume_rsp();
  endtask

  task automatic test_resp_stall();
    bit bad = 1'b0;
    stub_en = 1'b1; stub_delay = 2; stub_data = 32'h1234_5678;
    send_cmd(1'b0, {PAGE_MMIO, 24'h8}, 32'h0, 4'b0);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        #1 iomem_ready = 1'b1;
      end
      @(posedge clk); #1;
      if ({cmd_ready, rsp_valid, iomem_valid} !== 3'b010 ||
          rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
        bad = 1'b1;
      end
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL stall_hold: got rdy=%b rv=%b iv=%b rd=%h want 0 1 0 12345678",
               cmd_ready, rsp_valid, iomem_valid, rsp_rdata);
    end
    consume_rsp();
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_idle_ready: got %b want 1", cmd_ready);
    end
    // Stray ready while idle must not start anything.
    #1 iomem_ready = 1'b1;
    @(posedge clk); #1;
    compared++;
    if ({cmd_ready, rsp_valid, iomem_valid} !== 3'b100) begin
      mismatched++;
      $display("FAIL idle_stray: got %b want 100", {cmd_ready, rsp_valid, iomem_valid});
    end
  endtask

  task automatic test_reset_mid_bus();
    stub_en = 1'b0;
    send_cmd(1'b0, {PAGE_GPIO, 24'h20}, 32'h0, 4'b0);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    compared++;
    if ({iomem_valid, rsp_valid, cmd_ready} !== 3'b000) begin
      mismatched++;
      $display("FAIL rst_bus: got %b want 000", {iomem_valid, rsp_valid, cmd_ready});
    end
    @(negedge clk);
    resetn = 1'b1;
    stub_en = 1'b1; stub_delay = 2; stub_data = 32'h0000_0055;
    send_cmd(1'b0, {PAGE_GPIO, 24'h24}, 32'h0, 4'b0);
    wait_rsp();
    compared++;
    if ({vcyc, rsp_err, rsp_rdata} !== {32'd2, 1'b0, 32'h55}) begin
      mismatched++;
      $display("FAIL rst_recover: got cyc=%0d err=%b rd=%h want 2 0 55",
               vcyc, rsp_err, rsp_rdata);
    end
    consume_rsp();
  endtask

`ifdef IOMEM_INIT_TIMEOUT_EN
  task automatic test_timeout();
    stub_en = 1'b0;
    send_cmd(1'b0, {PAGE_MMIO, 24'h0}, 32'h0, 4'b0);
    wait_rsp();
    compared++;
    if ({vcyc, rsp_err, rsp_rdata} !== {32'd8, 1'b1, 32'h0}) begin
      mismatched++;
      $display("FAIL tmo: got cyc=%0d err=%b rd=%h want 8 1 0",
               vcyc, rsp_err, rsp_rdata);
    end
    consume_rsp();
  endtask

  task automatic test_timeout_race();
    stub_en = 1'b1; stub_delay = 8; stub_data = 32'h0000_CAFE;
    send_cmd(1'b0, {PAGE_MMIO, 24'h4}, 32'h0, 4'b0);
    wait_rsp();
    compared++;
    if ({vcyc, rsp_err, rsp_rdata} !== {32'd8, 1'b0, 32'h0000_CAFE}) begin
      mismatched++;
      $display("FAIL tmo_race: got cyc=%0d err=%b rd=%h want 8 0 cafe",
               vcyc, rsp_err, rsp_rdata);
    end
    consume_rsp();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wstrb_zero();
    test_resp_stall();
    test_reset_mid_bus();
`ifdef IOMEM_INIT_TIMEOUT_EN
    test_timeout();
    test_timeout_race();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
